fifo_read_ctrl: RTL
===================

Name: fifo_read_ctrl

Overview:
- Read-domain controller for the async FIFO.
- Owns the binary/Gray read pointer and synchronises the write-domain Gray pointer into rclk.
- Generates empty and fill level, drives the read address into memory_element.
- Presents data through a registered first-word-fall-through (FWFT) output stage with a valid/ready handshake.

Parameters:
DSIZE, 8, data word width in bits
ADDRESS_SIZE, 4, memory address width; depth = 2**ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits

Ports:
rclk  input  1  read-domain clock; all state updates on posedge
rrst  input  1  synchronous, active-high reset
wptr_gray  input  ADDRESS_SIZE+1  write pointer, Gray coded, from write domain (asynchronous to rclk)
rdata  input  DSIZE  combinational read data from memory_element at raddr
raddr  output  ADDRESS_SIZE  memory read address = rbin[ADDRESS_SIZE-1:0]
rptr_gray  output  ADDRESS_SIZE+1  registered Gray read pointer, to write-domain synchroniser
rempty  output  1  registered; 1 = no unread word left in memory
rlevel  output  ADDRESS_SIZE+1  registered count of words in memory not yet fetched (excludes output register)
dout  output  DSIZE  output data register
dout_valid  output  1  dout holds a word not yet accepted
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready

Behaviour:
- Reset (rrst=1 at posedge): rbin=0, rptr_gray=0, sync flops=0, rempty=1, rlevel=0, dout=0, dout_valid=0. Reset has priority over every other event.
- Synchroniser: two flops, wptr_gray -> rq1 -> rq2_wptr. No logic between the flops.
- Internal read strobe: rinc = !rempty && (!dout_valid || dout_ready).
- Pointer: rbinnext = rbin + rinc, modulo 2**(ADDRESS_SIZE+1), natural wrap.
  - rgraynext = rbinnext ^ (rbinnext >> 1).
  - rbin and rptr_gray register rbinnext and rgraynext each edge.
- Empty: rempty <= (rgraynext == rq2_wptr), compared at full ADDRESS_SIZE+1 width, so wrap-around needs no special case.
- Level: rlevel <= gray2bin(rq2_wptr) - rbinnext, modulo 2**(ADDRESS_SIZE+1). Range 0..2**ADDRESS_SIZE.
- Output stage:
  - On rinc: dout <= rdata (memory word at the current raddr); dout_valid <= 1.
  - Else if dout_valid && dout_ready: dout_valid <= 0; dout holds its value.
  - Accept and refill in the same edge: dout_valid stays 1, dout is replaced. This gives zero-bubble streaming.
  - dout_ready while dout_valid=0 has no effect.
  - dout and dout_valid do not change while dout_valid && !dout_ready.
- Latency: wptr_gray stable before edge 1 -> rq2 updates at edge 2 -> rempty=0 and rlevel updated at edge 3 -> dout_valid=1 at edge 4.
- Backpressure: at most one word prefetched. Memory words are not consumed while the output stage is full and stalled.
- Underflow cannot occur: rinc is gated by rempty.
- Empty deassertion is pessimistic by the synchroniser latency. A transient (not yet synchronised) write pointer only delays rempty deassertion and never produces a false non-empty.
- Reset mid-operation: the prefetched word is discarded and pointers return to 0. The write side must be reset in the same reset window; this is a system requirement and is not checked here.

Decomposition:
- Package fifo_pkg:
  - default DSIZE/ADDRESS_SIZE constants;
  - functions bin2gray and gray2bin, parameterised by width;
  - typedef for the pointer width.
- Sub-module sync_2ff (parameter WIDTH; ports rclk, rrst, d, q) implements the two-flop synchroniser. It is reused later by the write-side controller.

Test Plan (DSIZE=8, ADDRESS_SIZE=4, memory model preloaded mem[i]=8'hA0+i):
- Reset: rrst=1 for 2 cycles with wptr_gray=0 -> rempty=1, dout_valid=0, raddr=0, rptr_gray=5'b00000, rlevel=0.
- Single word, dout_ready=0:
  - wptr_gray=5'b00001 before edge 1 -> edge 3: rempty=0, rlevel=1.
  - edge 4: dout=8'hA0, dout_valid=1, raddr=1, rptr_gray=5'b00001, rempty=1, rlevel=0.
  - dout holds with dout_ready=0.
- Backpressure: wptr_gray=gray(3)=5'b00010, dout_ready=0 -> dout=8'hA0 held, rlevel settles at 2, raddr=1.
  - Then dout_ready=1 -> beats A0, A1, A2 on consecutive cycles, then dout_valid=0, rempty=1.
- Full streaming: wptr_gray=gray(16)=5'b11000, dout_ready=1 -> 16 back-to-back beats A0..AF, no bubbles, rptr_gray ends at 5'b11000, rempty=1.
- Wrap-around: advance both pointers through binary 31->0 -> raddr 15->0 correct, data order preserved, rempty asserts exactly when rptr_gray==rq2_wptr.
- Reset mid-stream: rrst=1 while dout_valid=1, rlevel=5 -> next edge: all outputs at reset values, irrespective of dout_ready.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO controllers.
// Contents:
//   DEFAULT_DSIZE / DEFAULT_ADDRESS_SIZE : default data width and address width
//   ptr_t                                : pointer type (ADDRESS_SIZE+1 bits) at default sizing
//   bin2gray / gray2bin                  : code conversions on values up to 32 bits wide
// The conversions run on a 32-bit carrier. Callers zero-extend narrower pointers and
// truncate the result; zero upper bits make the result exact for any narrower width.
package fifo_pkg;

  localparam int unsigned DEFAULT_DSIZE        = 8;
  localparam int unsigned DEFAULT_ADDRESS_SIZE = 4;

  typedef logic [DEFAULT_ADDRESS_SIZE:0] ptr_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above its position.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a multi-bit Gray-coded bus crossing into the rclk domain.
// Ports:
//   rclk : destination clock
//   rrst : synchronous active-high reset, clears both stages
//   d    : asynchronous input bus
//   q    : synchronised output (two rclk edges of latency)
// No logic sits between the stages so the first flop has a full cycle to resolve.
module sync_2ff #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1_q, q1_d;
  logic [WIDTH-1:0] q2_q, q2_d;

  always_comb begin
    q1_d = d;
    q2_d = q1_q;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign q = q2_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller for the async FIFO.
// Owns the binary/Gray read pointer, synchronises the write Gray pointer into rclk,
// produces empty and fill level, and presents data through a registered
// first-word-fall-through output stage with a valid/ready handshake.
// Ports:
//   rclk       : read clock
//   rrst       : synchronous active-high reset
//   wptr_gray  : write pointer, Gray coded, asynchronous to rclk
//   rdata      : combinational memory read data at raddr
//   raddr      : memory read address (low bits of the binary read pointer)
//   rptr_gray  : registered Gray read pointer for the write-domain synchroniser
//   rempty     : no unread word left in memory
//   rlevel     : words in memory not yet fetched (output register excluded)
//   dout       : output data register
//   dout_valid : dout holds a word not yet accepted
//   dout_ready : consumer accepts dout when dout_valid && dout_ready
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE        = DEFAULT_DSIZE,
  parameter int unsigned ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic [ADDRESS_SIZE:0]   wptr_gray,
  input  logic [DSIZE-1:0]        rdata,
  output logic [ADDRESS_SIZE-1:0] raddr,
  output logic [ADDRESS_SIZE:0]   rptr_gray,
  output logic                    rempty,
  output logic [ADDRESS_SIZE:0]   rlevel,
  output logic [DSIZE-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready
);

  localparam int unsigned PW = ADDRESS_SIZE + 1;

  logic [PW-1:0]    rq2_wptr;
  logic [PW-1:0]    wbin_sync;
  logic             rinc;

  logic [PW-1:0]    rbin_q, rbin_d;
  logic [PW-1:0]    rgray_q, rgray_d;
  logic             rempty_q, rempty_d;
  logic [PW-1:0]    rlevel_q, rlevel_d;
  logic [DSIZE-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  sync_2ff #(
    .WIDTH(PW)
  ) u_sync_wptr (
    .rclk(rclk),
    .rrst(rrst),
    .d   (wptr_gray),
    .q   (rq2_wptr)
  );

  always_comb begin
    // Fetch whenever memory has a word and the output stage is empty or draining.
    rinc      = !rempty_q && (!dout_valid_q || dout_ready);
    rbin_d    = rbin_q + PW'(rinc);
    rgray_d   = PW'(bin2gray(32'(rbin_d)));
    wbin_sync = PW'(gray2bin(32'(rq2_wptr)));
    // Full-width compare: the extra MSB disambiguates wrap-around.
    rempty_d  = (rgray_d == rq2_wptr);
    rlevel_d  = wbin_sync - rbin_d;

    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (rinc) begin
      dout_d       = rdata;
      dout_valid_d = 1'b1;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      rempty_q     <= 1'b1;
      rlevel_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rgray_q      <= rgray_d;
      rempty_q     <= rempty_d;
      rlevel_q     <= rlevel_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign raddr      = rbin_q[ADDRESS_SIZE-1:0];
  assign rptr_gray  = rgray_q;
  assign rempty     = rempty_q;
  assign rlevel     = rlevel_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
